// File: rtl/lifo_pop_ctrl.sv
// lifo_pop_ctrl: read-side controller for a LIFO buffer.
// Pops cmd_len words from the LIFO into a 2-entry skid FIFO and streams them
// out on a valid/ready port, then reports completion with a count and an
// underrun flag.
//
// Ports:
//   clk, reset               clock, async active-high reset
//   cmd_valid/ready/len      pop request handshake (ready only in IDLE)
//   lifo_val/data/read       LIFO side: non-empty flag, top word, pop strobe
//   out_valid/ready/data/last output word stream, last on the cmd_len-th word
//   done/done_cnt/underrun   one-cycle completion report
module lifo_pop_ctrl #(
    parameter int DATA_W = 8,
    parameter int LEN_W  = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [LEN_W-1:0]  cmd_len,
    input  logic              lifo_val,
    input  logic [DATA_W-1:0] lifo_data,
    output logic              lifo_read,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_last,
    output logic              done,
    output logic [LEN_W-1:0]  done_cnt,
    output logic              underrun
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_POP,
        S_DRAIN
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;

    logic [LEN_W-1:0]  r_rem;
    logic [LEN_W-1:0]  r_popped;
    logic              r_under;

    logic [DATA_W-1:0] r_sk_data [2];
    logic [1:0]        r_sk_last;
    logic              r_wptr;
    logic              r_rptr;
    logic [1:0]        r_cnt;

    logic              r_done;
    logic [LEN_W-1:0]  r_done_cnt;
    logic              r_done_und;

    logic              w_cmd_hs;
    logic              w_pop;
    logic              w_drained;
    logic              w_under_set;
    logic              w_done_set;
    logic [LEN_W-1:0]  w_done_cnt_nxt;
    logic              w_done_und_nxt;

    assign w_cmd_hs  = cmd_valid & cmd_ready;
    assign w_pop     = out_valid & out_ready;
    // Skid empties this cycle: already empty, or its last entry leaves now.
    assign w_drained = (r_cnt == 2'd0) | ((r_cnt == 2'd1) & w_pop);

    assign out_valid = (r_cnt != 2'd0);
    assign out_data  = r_sk_data[r_rptr];
    assign out_last  = r_sk_last[r_rptr];
    assign done      = r_done;
    assign done_cnt  = r_done_cnt;
    assign underrun  = r_done_und;

    always_comb begin
        w_state_nxt    = r_state;
        cmd_ready      = 1'b0;
        lifo_read      = 1'b0;
        w_under_set    = 1'b0;
        w_done_set     = 1'b0;
        w_done_cnt_nxt = '0;
        w_done_und_nxt = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) begin
                    if (cmd_len == '0) begin
                        w_done_set = 1'b1;
                    end else begin
                        w_state_nxt = S_POP;
                    end
                end
            end
            S_POP: begin
                // The pop strobe never looks at out_ready: only skid space.
                if (!lifo_val) begin
                    w_state_nxt = S_DRAIN;
                    w_under_set = 1'b1;
                end else if (r_cnt != 2'd2) begin
                    lifo_read = 1'b1;
                    if (r_rem == LEN_W'(1)) begin
                        w_state_nxt = S_DRAIN;
                    end
                end
            end
            S_DRAIN: begin
                if (w_drained) begin
                    w_state_nxt    = S_IDLE;
                    w_done_set     = 1'b1;
                    w_done_cnt_nxt = r_popped;
                    w_done_und_nxt = r_under;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_rem      <= '0;
            r_popped   <= '0;
            r_under    <= 1'b0;
            r_done     <= 1'b0;
            r_done_cnt <= '0;
            r_done_und <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_cmd_hs) begin
                r_rem    <= cmd_len;
                r_popped <= '0;
                r_under  <= 1'b0;
            end else if (lifo_read) begin
                r_rem    <= r_rem - LEN_W'(1);
                r_popped <= r_popped + LEN_W'(1);
            end
            if (w_under_set) begin
                r_under <= 1'b1;
            end
            r_done <= w_done_set;
            if (w_done_set) begin
                r_done_cnt <= w_done_cnt_nxt;
                r_done_und <= w_done_und_nxt;
            end
        end
    end

    // 2-entry skid FIFO between the LIFO pop and the output port.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sk_data[0] <= '0;
            r_sk_data[1] <= '0;
            r_sk_last    <= '0;
            r_wptr       <= 1'b0;
            r_rptr       <= 1'b0;
            r_cnt        <= 2'd0;
        end else begin
            if (lifo_read) begin
                r_sk_data[r_wptr] <= lifo_data;
                r_sk_last[r_wptr] <= (r_rem == LEN_W'(1));
                r_wptr            <= ~r_wptr;
            end
            if (w_pop) begin
                r_rptr <= ~r_rptr;
            end
            r_cnt <= r_cnt + {1'b0, lifo_read} - {1'b0, w_pop};
        end
    end

endmodule

// File: tb/tb_lifo_pop_ctrl.sv
// tb_lifo_pop_ctrl: directed bench for lifo_pop_ctrl with a behavioural LIFO.
// Per-cycle vector table for the simple flows, hand sequences for stalls,
// reset and back-to-back commands.
module tb_lifo_pop_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [3:0] cmd_len;
    logic       lifo_val;
    logic [7:0] lifo_data;
    logic       lifo_read;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_data;
    logic       out_last;
    logic       done;
    logic [3:0] done_cnt;
    logic       underrun;

    always #5 clk = ~clk;

    lifo_pop_ctrl #(.DATA_W(8), .LEN_W(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_len   (cmd_len),
        .lifo_val  (lifo_val),
        .lifo_data (lifo_data),
        .lifo_read (lifo_read),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_last  (out_last),
        .done      (done),
        .done_cnt  (done_cnt),
        .underrun  (underrun)
    );

    // Behavioural LIFO
    logic [7:0] stk [0:31];
    logic [4:0] sp = 5'd0;
    logic       ld_en = 1'b0;
    logic       ld_clr = 1'b0;
    logic [7:0] ld_data = 8'h00;

    always @(posedge clk) begin
        if (ld_clr) begin
            sp <= 5'd0;
        end else if (lifo_read) begin
            sp <= sp - 5'd1;
        end else if (ld_en) begin
            stk[sp] <= ld_data;
            sp      <= sp + 5'd1;
        end
    end

    assign lifo_val  = (sp != 5'd0);
    assign lifo_data = lifo_val ? stk[sp - 5'd1] : 8'h00;

    int checks = 0;
    int failures = 0;
    int ncyc = 0;
    int nrd = 0;
    int viol = 0;

    int obs_d[$];
    int obs_l[$];
    int dn_cnt[$];
    int dn_und[$];
    int dn_cyc[$];
    int hs_cyc[$];

    typedef struct {
        logic       cv;
        logic [3:0] len;
        logic       ordy;
        logic       e_crdy;
        logic       e_rd;
        logic       e_ov;
        logic [7:0] e_d;
        logic       e_last;
        logic       e_done;
        logic [3:0] e_cnt;
        logic       e_und;
    } vec_t;

    vec_t vt [16];

    function automatic vec_t mk(
        logic cv, logic [3:0] len, logic ordy,
        logic crdy, logic rd, logic ov, logic [7:0] d,
        logic lst, logic dn, logic [3:0] cnt, logic und
    );
        vec_t v;
        v.cv = cv; v.len = len; v.ordy = ordy;
        v.e_crdy = crdy; v.e_rd = rd; v.e_ov = ov; v.e_d = d;
        v.e_last = lst; v.e_done = dn; v.e_cnt = cnt; v.e_und = und;
        return v;
    endfunction

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic clear_logs();
        obs_d.delete(); obs_l.delete();
        dn_cnt.delete(); dn_und.delete(); dn_cyc.delete();
        hs_cyc.delete();
        nrd = 0;
    endtask

    // One clock cycle: drive inputs mid-cycle, then observe settled outputs.
    task automatic cyc(input logic cv, input logic [3:0] len, input logic ordy);
        @(negedge clk);
        cmd_valid = cv;
        cmd_len   = len;
        out_ready = ordy;
        #1;
        ncyc++;
        if (out_valid && out_ready) begin
            obs_d.push_back(int'(out_data));
            obs_l.push_back(int'(out_last));
        end
        if (lifo_read) nrd++;
        if (lifo_read && !lifo_val) viol++;
        if (done) begin
            dn_cnt.push_back(int'(done_cnt));
            dn_und.push_back(int'(underrun));
            dn_cyc.push_back(ncyc);
        end
        if (cmd_valid && cmd_ready) hs_cyc.push_back(ncyc);
    endtask

    task automatic load(input logic [7:0] d);
        @(negedge clk);
        cmd_valid = 1'b0;
        ld_en   = 1'b1;
        ld_data = d;
        @(posedge clk);
        #1;
        ld_en = 1'b0;
    endtask

    task automatic lifo_clear();
        @(negedge clk);
        ld_clr = 1'b1;
        @(posedge clk);
        #1;
        ld_clr = 1'b0;
    endtask

    task automatic run_vecs(input int first, input int last);
        for (int i = first; i <= last; i++) begin
            cyc(vt[i].cv, vt[i].len, vt[i].ordy);
            chk($sformatf("v%0d_cmd_ready", i), int'(cmd_ready), int'(vt[i].e_crdy));
            chk($sformatf("v%0d_lifo_read", i), int'(lifo_read), int'(vt[i].e_rd));
            chk($sformatf("v%0d_out_valid", i), int'(out_valid), int'(vt[i].e_ov));
            chk($sformatf("v%0d_done", i), int'(done), int'(vt[i].e_done));
            if (vt[i].e_ov) begin
                chk($sformatf("v%0d_out_data", i), int'(out_data), int'(vt[i].e_d));
                chk($sformatf("v%0d_out_last", i), int'(out_last), int'(vt[i].e_last));
            end
            if (vt[i].e_done) begin
                chk($sformatf("v%0d_done_cnt", i), int'(done_cnt), int'(vt[i].e_cnt));
                chk($sformatf("v%0d_underrun", i), int'(underrun), int'(vt[i].e_und));
            end
        end
    endtask

    task automatic chk_stream(input string nm, input int ed[$], input int el[$]);
        chk({nm, "_nwords"}, obs_d.size(), ed.size());
        for (int i = 0; i < ed.size() && i < obs_d.size(); i++) begin
            chk($sformatf("%s_w%0d_data", nm, i), obs_d[i], ed[i]);
            chk($sformatf("%s_w%0d_last", nm, i), obs_l[i], el[i]);
        end
    endtask

    task automatic run_to_done(input string nm, input int ndone, input logic [3:0] len);
        int k;
        k = 0;
        while (dn_cnt.size() < ndone && k < 40) begin
            cyc(1'b0, len, 1'b1);
            k++;
        end
        chk({nm, "_done_seen"}, dn_cnt.size(), ndone);
    endtask

    initial begin
        bit stable_bad;
        int k;

        // Test 1: A1,A2,A3 loaded, len=3
        vt[0]  = mk(1, 3, 1, 1, 0, 0, 8'h00, 0, 0, 0, 0);
        vt[1]  = mk(0, 3, 1, 0, 1, 0, 8'h00, 0, 0, 0, 0);
        vt[2]  = mk(0, 3, 1, 0, 1, 1, 8'hA3, 0, 0, 0, 0);
        vt[3]  = mk(0, 3, 1, 0, 1, 1, 8'hA2, 0, 0, 0, 0);
        vt[4]  = mk(0, 3, 1, 0, 0, 1, 8'hA1, 1, 0, 0, 0);
        vt[5]  = mk(0, 3, 1, 1, 0, 0, 8'h00, 0, 1, 3, 0);
        // Test 4: len=0
        vt[6]  = mk(1, 0, 1, 1, 0, 0, 8'h00, 0, 0, 0, 0);
        vt[7]  = mk(0, 0, 1, 1, 0, 0, 8'h00, 0, 1, 0, 0);
        vt[8]  = mk(0, 0, 1, 1, 0, 0, 8'h00, 0, 0, 0, 0);
        // Test 2: B1,B2 loaded, len=5 -> underrun
        vt[9]  = mk(1, 5, 1, 1, 0, 0, 8'h00, 0, 0, 0, 0);
        vt[10] = mk(0, 5, 1, 0, 1, 0, 8'h00, 0, 0, 0, 0);
        vt[11] = mk(0, 5, 1, 0, 1, 1, 8'hB2, 0, 0, 0, 0);
        vt[12] = mk(0, 5, 1, 0, 0, 1, 8'hB1, 0, 0, 0, 0);
        vt[13] = mk(0, 5, 1, 0, 0, 0, 8'h00, 0, 0, 0, 0);
        vt[14] = mk(0, 5, 1, 1, 0, 0, 8'h00, 0, 1, 2, 1);
        vt[15] = mk(0, 5, 1, 1, 0, 0, 8'h00, 0, 0, 0, 0);

        reset     = 1'b1;
        cmd_valid = 1'b0;
        cmd_len   = 4'd0;
        out_ready = 1'b1;
        ld_clr    = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        ld_clr = 1'b0;
        chk("rst_cmd_ready", int'(cmd_ready), 1);
        chk("rst_lifo_read", int'(lifo_read), 0);
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_out_data", int'(out_data), 0);
        chk("rst_out_last", int'(out_last), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_done_cnt", int'(done_cnt), 0);
        chk("rst_underrun", int'(underrun), 0);
        reset = 1'b0;

        load(8'hA1); load(8'hA2); load(8'hA3);
        run_vecs(0, 8);
        load(8'hB1); load(8'hB2);
        run_vecs(9, 15);

        // Test 3: output stalled for 6 cycles
        lifo_clear();
        load(8'hC1); load(8'hC2); load(8'hC3); load(8'hC4);
        clear_logs();
        stable_bad = 1'b0;
        for (int i = 0; i < 6; i++) begin
            cyc(i == 0, 4'd4, 1'b0);
            if (i >= 2 && !(out_valid && out_data == 8'hC4)) stable_bad = 1'b1;
        end
        chk("t3_stall_reads", nrd, 2);
        chk("t3_head_stable", int'(stable_bad), 0);
        run_to_done("t3", 1, 4'd4);
        chk_stream("t3", '{8'hC4, 8'hC3, 8'hC2, 8'hC1}, '{0, 0, 0, 1});
        if (dn_cnt.size() > 0) begin
            chk("t3_done_cnt", dn_cnt[0], 4);
            chk("t3_underrun", dn_und[0], 0);
        end

        // Test 5: async reset mid-POP after 2 pops
        lifo_clear();
        load(8'hD1); load(8'hD2); load(8'hD3);
        load(8'hD4); load(8'hD5); load(8'hD6);
        clear_logs();
        cyc(1'b1, 4'd6, 1'b1);
        cyc(1'b0, 4'd6, 1'b1);
        cyc(1'b0, 4'd6, 1'b1);
        chk("t5_pops_before_rst", nrd, 2);
        @(negedge clk);
        #2;
        chk("t5_read_pre_rst", int'(lifo_read), 1);
        reset = 1'b1;
        #1;
        chk("t5_rst_lifo_read", int'(lifo_read), 0);
        chk("t5_rst_out_valid", int'(out_valid), 0);
        chk("t5_rst_done", int'(done), 0);
        chk("t5_rst_cmd_ready", int'(cmd_ready), 1);
        @(negedge clk);
        reset = 1'b0;
        lifo_clear();
        load(8'hE1);
        clear_logs();
        cyc(1'b1, 4'd1, 1'b1);
        run_to_done("t5", 1, 4'd1);
        chk_stream("t5", '{8'hE1}, '{1});
        if (dn_cnt.size() > 0) begin
            chk("t5_done_cnt", dn_cnt[0], 1);
            chk("t5_underrun", dn_und[0], 0);
        end

        // Test 6: back-to-back len=2 commands, cmd_valid held
        lifo_clear();
        load(8'hF1); load(8'hF2); load(8'hF3); load(8'hF4);
        clear_logs();
        k = 0;
        while (dn_cnt.size() < 2 && k < 40) begin
            cyc(hs_cyc.size() < 2, 4'd2, 1'b1);
            k++;
        end
        chk("t6_done_pulses", dn_cnt.size(), 2);
        chk("t6_handshakes", hs_cyc.size(), 2);
        chk_stream("t6", '{8'hF4, 8'hF3, 8'hF2, 8'hF1}, '{0, 1, 0, 1});
        if (dn_cnt.size() == 2 && hs_cyc.size() == 2) begin
            chk("t6_done0_cnt", dn_cnt[0], 2);
            chk("t6_done1_cnt", dn_cnt[1], 2);
            chk("t6_done1_und", dn_und[1], 0);
            chk("t6_hs2_in_done_cycle", hs_cyc[1], dn_cyc[0]);
        end

        chk("read_while_empty", viol, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
